// File: rtl/output_driver.sv
// Output conditioning for one relay/valve/enable pin.
// Samples the logical request on poll ticks, enforces minimum ON and OFF
// times, applies output polarity, and checks the pin through a synchronised
// readback. A persistent readback mismatch sets a sticky fault, which turns
// the output off through the normal minimum-off path.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_OFF      | logically off, waiting for an effective request
// S_ON_HOLD  | logically on, minimum-on time running, request ignored
// S_ON       | logically on, follows request, readback checked
// S_OFF_HOLD | logically off, minimum-off time running, request ignored
module output_driver #(
  parameter int SYS_CLOCK  = 72_000_000,
  parameter int POLL_CLOCK = 100_000,
  parameter int MIN_ON     = 16,
  parameter int MIN_OFF    = 16,
  parameter int FB_DELAY   = 32,
  parameter bit FB_EN      = 1'b1
) (
  input  logic clock,
  input  logic aclr_n,
  input  logic sclr,
  input  logic req,
  input  logic level,
  input  logic fb,
  output logic out,
  output logic ready,
  output logic busy,
  output logic fault
);

  localparam int MAX  = SYS_CLOCK / POLL_CLOCK - 1;
  localparam int PW   = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam int HMAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int MW   = $clog2(FB_DELAY + 1);

  localparam logic [PW-1:0] CNT_MAX  = PW'(MAX);
  localparam logic [HW-1:0] ON_LAST  = HW'(MIN_ON);
  localparam logic [HW-1:0] OFF_LAST = HW'(MIN_OFF);
  localparam logic [MW-1:0] MIS_LIM  = MW'(FB_DELAY);

  typedef enum logic [1:0] {
    S_OFF      = 2'd0,
    S_ON_HOLD  = 2'd1,
    S_ON       = 2'd2,
    S_OFF_HOLD = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   pre_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_next;
  logic [MW-1:0]   mis_cnt;
  logic [MW-1:0]   mis_next;
  logic [2:0]      fb_sync;
  logic            tick;
  logic            log_on;
  logic            stable;
  logic            mismatch;
  logic            fault_set;
  logic            eff_req;

  // Tick decode, readback compare and effective request.
  // A fault raised on this tick already blocks the request, so S_ON leaves
  // on the very edge the fault is recorded.
  always_comb begin
    tick      = (pre_cnt == CNT_MAX);
    log_on    = (state == S_ON_HOLD) || (state == S_ON);
    stable    = (state == S_ON) || (state == S_OFF);
    mismatch  = (fb_sync[2] ^ level) != log_on;
    hold_next = hold_cnt + HW'(1);
    mis_next  = (mis_cnt == MIS_LIM) ? mis_cnt : mis_cnt + MW'(1);
    fault_set = FB_EN && tick && stable && mismatch && (mis_next == MIS_LIM);
    eff_req   = req && ready && !fault && !fault_set;
  end

  // Poll prescaler and ready flag.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      pre_cnt <= '0;
      ready   <= 1'b0;
    end else if (sclr) begin
      pre_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick) ready <= 1'b1;
    end
  end

  // Three-flop synchroniser for the asynchronous pin readback.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n)   fb_sync <= '0;
    else if (sclr) fb_sync <= '0;
    else           fb_sync <= {fb_sync[1:0], fb};
  end

  // Minimum on/off sequencer, advancing only on poll ticks.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state    <= S_OFF;
      hold_cnt <= '0;
    end else if (sclr) begin
      state    <= S_OFF;
      hold_cnt <= '0;
    end else if (tick) begin
      case (state)
        S_OFF: begin
          if (eff_req) begin
            state    <= S_ON_HOLD;
            hold_cnt <= '0;
          end
        end
        S_ON_HOLD: begin
          if (hold_next == ON_LAST) begin
            state    <= eff_req ? S_ON : S_OFF_HOLD;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_next;
          end
        end
        S_ON: begin
          if (!eff_req) begin
            state    <= S_OFF_HOLD;
            hold_cnt <= '0;
          end
        end
        S_OFF_HOLD: begin
          if (hold_next == OFF_LAST) begin
            state    <= eff_req ? S_ON_HOLD : S_OFF;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_next;
          end
        end
        default: begin
          state    <= S_OFF;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Readback mismatch counter and sticky fault; hold states act as settling windows.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      mis_cnt <= '0;
      fault   <= 1'b0;
    end else if (sclr || !FB_EN) begin
      mis_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      if (tick) mis_cnt <= (stable && mismatch) ? mis_next : '0;
      if (fault_set) fault <= 1'b1;
    end
  end

  // Registered pin drive with polarity, and hold indication.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      out  <= 1'b0;
      busy <= 1'b0;
    end else if (sclr) begin
      out  <= 1'b0;
      busy <= 1'b0;
    end else begin
      out  <= log_on ^ level;
      busy <= (state == S_ON_HOLD) || (state == S_OFF_HOLD);
    end
  end

endmodule

// File: tb/tb_output_driver.sv
// Directed bench for output_driver: tick every 4 clocks, MIN_ON=3,
// MIN_OFF=2, FB_DELAY=4. edge_n counts clock edges since the last
// reset/sclr release; tick edges are multiples of 4.
module tb_output_driver;

  logic clock   = 1'b0;
  logic aclr_n  = 1'b0;
  logic sclr    = 1'b0;
  logic req     = 1'b0;
  logic level   = 1'b0;
  logic fb_drv  = 1'b0;
  logic fb_mode = 1'b0;
  logic [7:0] dly = '0;
  logic fb;
  logic out, ready, busy, fault;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  output_driver #(
    .SYS_CLOCK (1000),
    .POLL_CLOCK(250),
    .MIN_ON    (3),
    .MIN_OFF   (2),
    .FB_DELAY  (4),
    .FB_EN     (1'b1)
  ) dut (
    .clock (clock),
    .aclr_n(aclr_n),
    .sclr  (sclr),
    .req   (req),
    .level (level),
    .fb    (fb),
    .out   (out),
    .ready (ready),
    .busy  (busy),
    .fault (fault)
  );

  always #5 clock = ~clock;

  // External pin model: readback lags the drive by 8 clocks (2 ticks).
  always @(posedge clock) dly <= {dly[6:0], out};
  assign fb = fb_mode ? dly[7] : fb_drv;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      edge_n++;
    end
  endtask

  task automatic to_edge(input int e);
    while (edge_n < e) cyc(1);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic o, input logic r,
                    input logic b, input logic f);
    chk({tag, ".out"}, out, o);
    chk({tag, ".ready"}, ready, r);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".fault"}, fault, f);
  endtask

  initial begin
    // 1: reset state, ready after 4th clock, early request ignored
    aclr_n = 1'b0; level = 1'b0; req = 1'b1;
    #3;
    st("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2);
    aclr_n = 1'b1; edge_n = 0;
    to_edge(3); chk("ready_pre", ready, 1'b0);
    to_edge(4); chk("ready_first_tick", ready, 1'b1);
    to_edge(5); chk("early_req_out", out, 1'b0); chk("early_req_busy", busy, 1'b0);
    req = 1'b0;

    // 2: single-tick request gives a 12-clock pulse, then 8-clock minimum gap
    to_edge(7); req = 1'b1;
    to_edge(8); req = 1'b0; chk("pulse_pre", out, 1'b0);
    to_edge(9); chk("pulse_rise", out, 1'b1); chk("pulse_busy", busy, 1'b1);
    for (int e = 10; e <= 20; e++) begin
      to_edge(e); chk("pulse_hold", out, 1'b1); chk("pulse_hold_busy", busy, 1'b1);
    end
    to_edge(21); chk("pulse_fall", out, 1'b0); chk("off_hold_busy", busy, 1'b1);
    req = 1'b1;
    for (int e = 22; e <= 28; e++) begin
      to_edge(e); chk("min_off_gap", out, 1'b0);
    end
    to_edge(29); chk("min_off_rise", out, 1'b1); chk("min_off_rise_busy", busy, 1'b1);

    // 4: fb stuck at 0 while ON -> fault on 4th tick in S_ON
    to_edge(40); chk("on_hold_end_busy", busy, 1'b1);
    to_edge(41); chk("s_on_busy", busy, 1'b0); chk("s_on_out", out, 1'b1);
    to_edge(55); chk("pre_fault", fault, 1'b0); chk("pre_fault_out", out, 1'b1);
    to_edge(56); chk("fault_set", fault, 1'b1); chk("fault_edge_out", out, 1'b1);
    to_edge(57); chk("fault_out_off", out, 1'b0); chk("fault_off_hold", busy, 1'b1);
    to_edge(65); st("fault_idle", 1'b0, 1'b1, 1'b0, 1'b1);
    to_edge(80); chk("fault_sticky", fault, 1'b1); chk("fault_stays_off", out, 1'b0);

    // sclr clears the fault
    sclr = 1'b1; cyc(1);
    st("sclr_clear", 1'b0, 1'b0, 1'b0, 1'b0);
    sclr = 1'b0; edge_n = 0; req = 1'b1;
    to_edge(4); chk("sclr_ready", ready, 1'b1);
    to_edge(5); chk("sclr_req_ignored", out, 1'b0);
    to_edge(9); chk("restart_rise", out, 1'b1);

    // 6: sclr during S_ON_HOLD
    to_edge(10); sclr = 1'b1; cyc(1);
    st("sclr_on_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    sclr = 1'b0; edge_n = 0;
    to_edge(3); chk("sclr2_ready_pre", ready, 1'b0);
    to_edge(4); chk("sclr2_ready", ready, 1'b1);
    to_edge(8); chk("sclr2_req_ignored", out, 1'b0);
    to_edge(9); chk("sclr2_rise", out, 1'b1); chk("sclr2_busy", busy, 1'b1);

    // async reset mid-pulse drops out without a clock edge
    #2; aclr_n = 1'b0; #1;
    chk("async_out", out, 1'b0); chk("async_busy", busy, 1'b0); chk("async_ready", ready, 1'b0);
    level = 1'b1; #1;
    chk("reset_level_out", out, 1'b0);

    // 3: inverted polarity
    cyc(1);
    aclr_n = 1'b1; edge_n = 0; fb_drv = 1'b0; req = 1'b1;
    to_edge(1); chk("inv_idle", out, 1'b1);
    to_edge(8); chk("inv_idle_late", out, 1'b1);
    to_edge(9); chk("inv_on", out, 1'b0); chk("inv_busy", busy, 1'b1);
    to_edge(20); chk("inv_hold_busy", busy, 1'b1);
    to_edge(21); st("inv_s_on", 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: matching delayed readback, request toggling every 5 ticks
    sclr = 1'b1; level = 1'b0; fb_mode = 1'b1; cyc(1);
    sclr = 1'b0; edge_n = 0;
    for (int k = 0; k < 20; k++) begin
      req = (k % 2 == 0);
      cyc(20);
      chk("delayed_fb_no_fault", fault, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
